riscv_pipelined_lsu: RTL and testbench
======================================

# riscv_pipelined_lsu

Load/store unit for the pipelined RISC-V core: sits in the MEM stage and consumes the memory controls produced by the decoder. The decoder produces the write enable, byte select and funct3. The LSU issues a handshaked request on the data bus, stalls the pipeline until the access completes, aligns store data onto byte lanes, and extracts and sign/zero-extends load data. It also flags misaligned accesses, illegal funct3 encodings and bus timeouts.

## Interface
Parameters:
- BUS_TIMEOUT, 16: maximum number of cycles spent in REQ+RESP before the access is aborted with a timeout fault.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  reset, asynchronous and active-high.
- i_lsu_req  in  1  MEM-stage instruction is a load or store; held stable while o_lsu_stall=1.
- i_lsu_wr_en  in  1  1=store, 0=load.
- i_lsu_funct3  in  3  access size and signedness: 0=b, 1=h, 2=w, 4=bu, 5=hu.
- i_lsu_addr  in  32  byte address.
- i_lsu_wdata  in  32  store data, right-aligned.
- o_lsu_rdata  out  32  extended load data; valid in DONE.
- o_lsu_stall  out  1  freeze the pipeline.
- o_lsu_fault  out  1  1-cycle pulse in DONE when the access failed.
- o_lsu_fault_code  out  2  01=misaligned, 10=timeout, 11=illegal funct3, 00=none.
- o_bus_valid  out  1  request valid.
- o_bus_wr  out  1  request is a write.
- o_bus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- o_bus_wdata  out  32  lane-replicated store data.
- o_bus_strb  out  4  byte strobes.
- i_bus_ready  in  1  request accepted this cycle.
- i_bus_rvalid  in  1  read data valid.
- i_bus_rdata  in  32  read word.

## Operation
- States: IDLE, REQ, RESP, DONE.
- IDLE, i_lsu_req=1:
  - Capture wr_en, funct3, addr and wdata.
  - Illegal funct3 (3, 6 or 7 for loads; anything other than 0–2 for stores) → DONE with fault 11.
  - Misaligned access (h/hu with addr[0]=1, or w with addr[1:0]≠0) → DONE with fault 01.
  - Illegal funct3 takes priority over misalignment. A faulted access never raises o_bus_valid.
  - Otherwise → REQ, and the timeout counter is cleared.
- REQ:
  - o_bus_valid=1; address, data and strobes are held stable until i_bus_ready.
  - On i_bus_ready: a store → DONE; a load → RESP.
- RESP: on i_bus_rvalid, register the extended data into o_lsu_rdata → DONE.
- DONE: o_lsu_stall=0, o_lsu_fault and o_lsu_fault_code valid; → IDLE unconditionally.
- Store strobes: b = 0001<<addr[1:0]; h = 0011<<addr[1:0]; w = 1111.
- Store wdata: b = {4{wdata[7:0]}}; h = {2{wdata[15:0]}}; w = wdata.
- Load data: select the byte or half lane by addr[1:0], then sign-extend for b/h or zero-extend for bu/hu. Word loads pass through unchanged.
- o_lsu_stall = (IDLE & i_lsu_req) | REQ | RESP (combinational).
- Timeout:
  - The counter increments each cycle in REQ or RESP.
  - If the counter reaches BUS_TIMEOUT-1 with no completion event that cycle → DONE with fault 10, o_lsu_rdata=0, o_bus_valid dropped.
  - A completion event (ready in REQ for a store, rvalid in RESP) in the same cycle beats the timeout.
- i_bus_rvalid outside RESP is ignored (late or stray responses).
- o_lsu_rdata holds its value outside DONE; it is cleared to 0 on any faulted access.

## Timing
- Reset values:
  - state=IDLE, counter=0.
  - o_lsu_rdata=0, o_lsu_fault=0, o_lsu_fault_code=00.
  - o_bus_valid=0, o_bus_wr=0, o_bus_addr=0, o_bus_wdata=0, o_bus_strb=0.
  - o_lsu_stall follows its formula (IDLE term only).
- Reset asserted mid-access: o_bus_valid drops immediately (asynchronously), the state returns to IDLE, and a pending response is discarded.
- Store with ready held high: stall for 2 cycles (IDLE, REQ), DONE in the 3rd cycle.
- Load with ready held high and rvalid one cycle after acceptance: stall for 3 cycles, DONE in the 4th cycle.
- Bus rule: rvalid arrives no earlier than the cycle after acceptance.
- Fault path from IDLE: stall for 1 cycle, DONE in the 2nd cycle.
- Back-to-back accesses: the next request is sampled in the cycle after DONE. There is no bus request in DONE.
- Cycles in REQ+RESP never exceed BUS_TIMEOUT.

## Test plan
- sw, addr 0x100, wdata 0xDEADBEEF, ready=1 → o_bus_valid for 1 cycle with addr 0x100, strb 1111, wr=1; stall high for 2 cycles; fault=0.
- sb, addr 0x103, wdata 0x000000A5 → bus addr 0x100, strb 1000, wdata 0xA5A5A5A5. sh at 0x102 with wdata 0x1234 → strb 1100, wdata 0x12341234.
- Loads from word 0x12803456:
  - lb at 0x102 → rdata 0xFFFFFF80; lbu at 0x102 → 0x00000080.
  - lh at 0x102 → 0x00001280; lw at 0x100 → 0x12803456.
  - Repeat with ready delayed 3 cycles and rvalid delayed 2 cycles; stall must cover the whole access.
- Faults:
  - lw at 0x101 → no o_bus_valid, stall for 1 cycle, fault pulse with code 01.
  - Load with funct3=3 → code 11.
  - sw with funct3=4 → code 11.
- BUS_TIMEOUT=4, load with ready never asserted → 4 cycles in REQ, then DONE with fault 10, rdata=0. A later stray rvalid in IDLE has no effect.
- Assert i_rst while in RESP → o_bus_valid=0 and state IDLE immediately; an rvalid during or after reset is ignored. A subsequent sw completes normally.

Source files
------------

// File: rtl/riscv_pipelined_lsu.sv
// MEM-stage load/store unit: handshaked data-bus access with pipeline stall,
// store lane alignment, load extraction/extension and fault reporting.
// Ports: i_lsu_* request from decode, o_lsu_* result/stall/fault to the
// pipeline, o_bus_*/i_bus_* word-aligned data bus (valid/ready, rvalid).
module riscv_pipelined_lsu #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lsu_req,
  input  logic        i_lsu_wr_en,
  input  logic [2:0]  i_lsu_funct3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_stall,
  output logic        o_lsu_fault,
  output logic [1:0]  o_lsu_fault_code,
  output logic        o_bus_valid,
  output logic        o_bus_wr,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_strb,
  input  logic        i_bus_ready,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  localparam int CW = $clog2(BUS_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    code_q, code_d;

  logic          illegal;
  logic          misal;
  logic          complete;
  logic          timeout;
  logic [31:0]   shifted;
  logic [31:0]   ext;
  logic [3:0]    strb;
  logic [31:0]   lanes;

  // Legality is judged on the live inputs, since it decides the IDLE exit.
  always_comb begin
    if (i_lsu_wr_en) begin
      illegal = i_lsu_funct3 > 3'd2;
    end else begin
      illegal = (i_lsu_funct3[1:0] == 2'd3) || (i_lsu_funct3 == 3'd6);
    end
    misal = ((i_lsu_funct3[1:0] == 2'd1) && i_lsu_addr[0]) ||
            ((i_lsu_funct3[1:0] == 2'd2) && (i_lsu_addr[1:0] != 2'd0));
  end

  always_comb begin
    shifted = i_bus_rdata >> {addr_q[1:0], 3'b000};
    unique case (f3_q)
      3'd0:    ext = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    ext = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    ext = {24'd0, shifted[7:0]};
      3'd5:    ext = {16'd0, shifted[15:0]};
      default: ext = i_bus_rdata;
    endcase
  end

  always_comb begin
    unique case (1'b1)
      (f3_q[1:0] == 2'd0): begin
        strb  = 4'b0001 << addr_q[1:0];
        lanes = {4{wdata_q[7:0]}};
      end
      (f3_q[1:0] == 2'd1): begin
        strb  = 4'b0011 << addr_q[1:0];
        lanes = {2{wdata_q[15:0]}};
      end
      default: begin
        strb  = 4'b1111;
        lanes = wdata_q;
      end
    endcase
  end

  // A completion in the last allowed cycle wins over the timeout.
  assign complete = ((state_q == REQ) && i_bus_ready && wr_q) ||
                    ((state_q == RESP) && i_bus_rvalid);
  assign timeout  = (cnt_q == CW'(BUS_TIMEOUT - 1)) && !complete;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (i_lsu_req) begin
          wr_d    = i_lsu_wr_en;
          f3_d    = i_lsu_funct3;
          addr_d  = i_lsu_addr;
          wdata_d = i_lsu_wdata;
          cnt_d   = '0;
          code_d  = 2'b00;
          if (illegal) begin
            code_d  = 2'b11;
            rdata_d = '0;
            state_d = DONE;
          end else if (misal) begin
            code_d  = 2'b01;
            rdata_d = '0;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (i_bus_ready && wr_q) begin
          state_d = DONE;
        end else if (timeout) begin
          code_d  = 2'b10;
          rdata_d = '0;
          state_d = DONE;
        end else if (i_bus_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (i_bus_rvalid) begin
          rdata_d = ext;
          state_d = DONE;
        end else if (timeout) begin
          code_d  = 2'b10;
          rdata_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      code_q  <= code_d;
    end
  end

  // Bus fields are gated by valid so they read as zero outside REQ.
  assign o_bus_valid      = state_q == REQ;
  assign o_bus_wr         = o_bus_valid && wr_q;
  assign o_bus_addr       = o_bus_valid ? {addr_q[31:2], 2'b00} : 32'd0;
  assign o_bus_wdata      = o_bus_valid ? lanes : 32'd0;
  assign o_bus_strb       = o_bus_valid ? strb : 4'd0;
  assign o_lsu_rdata      = rdata_q;
  assign o_lsu_stall      = ((state_q == IDLE) && i_lsu_req) ||
                            (state_q == REQ) || (state_q == RESP);
  assign o_lsu_fault      = (state_q == DONE) && (code_q != 2'b00);
  assign o_lsu_fault_code = (state_q == DONE) ? code_q : 2'b00;

endmodule

// File: tb/tb_riscv_pipelined_lsu.sv
// Directed self-checking bench for riscv_pipelined_lsu.
// dut uses the default timeout, dut2 uses BUS_TIMEOUT=4.
module tb_riscv_pipelined_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req, req2;
  logic        wr;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  logic        bus_ready, bus_rvalid, ready2, rvalid2;
  logic [31:0] bus_rdata;

  logic [31:0] rdata, rdata2;
  logic        stall, stall2, fault, fault2;
  logic [1:0]  code, code2;
  logic        bvalid, bvalid2, bwr, bwr2;
  logic [31:0] baddr, baddr2, bwdata, bwdata2;
  logic [3:0]  bstrb, bstrb2;

  int total = 0;
  int bad = 0;

  int          n_stall, n_valid;
  logic        r_done, r_wr, r_fault;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_strb;
  logic [1:0]  r_code;

  always #5 clk = ~clk;

  riscv_pipelined_lsu dut (
    .i_clk(clk), .i_rst(rst),
    .i_lsu_req(lsu_req), .i_lsu_wr_en(wr),
    .i_lsu_funct3(f3), .i_lsu_addr(addr),
    .i_lsu_wdata(wdata), .o_lsu_rdata(rdata),
    .o_lsu_stall(stall), .o_lsu_fault(fault),
    .o_lsu_fault_code(code), .o_bus_valid(bvalid),
    .o_bus_wr(bwr), .o_bus_addr(baddr),
    .o_bus_wdata(bwdata), .o_bus_strb(bstrb),
    .i_bus_ready(bus_ready), .i_bus_rvalid(bus_rvalid),
    .i_bus_rdata(bus_rdata)
  );

  riscv_pipelined_lsu #(.BUS_TIMEOUT(4)) dut2 (
    .i_clk(clk), .i_rst(rst),
    .i_lsu_req(req2), .i_lsu_wr_en(wr),
    .i_lsu_funct3(f3), .i_lsu_addr(addr),
    .i_lsu_wdata(wdata), .o_lsu_rdata(rdata2),
    .o_lsu_stall(stall2), .o_lsu_fault(fault2),
    .o_lsu_fault_code(code2), .o_bus_valid(bvalid2),
    .o_bus_wr(bwr2), .o_bus_addr(baddr2),
    .o_bus_wdata(bwdata2), .o_bus_strb(bstrb2),
    .i_bus_ready(ready2), .i_bus_rvalid(rvalid2),
    .i_bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one access on dut starting at #1 after a rising edge.
  // rdy_dly: valid cycles without ready; rv_dly: cycles from
  // acceptance to rvalid. Returns at #1 after the edge ending DONE.
  task automatic access(input logic w, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int rdy_dly, input int rv_dly,
                        input logic [31:0] word);
    int  acc_at;
    bit  rv_sent;
    lsu_req = 1'b1; wr = w; f3 = fn; addr = a; wdata = wd;
    n_stall = 0; n_valid = 0; r_done = 1'b0;
    r_addr = '0; r_strb = '0; r_wdata = '0; r_wr = 1'b0;
    acc_at = -1; rv_sent = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!r_done) begin
        bus_ready = bvalid && (n_valid >= rdy_dly) && (acc_at < 0);
        if (!w && acc_at >= 0 && !rv_sent && (c - acc_at) >= rv_dly) begin
          bus_rvalid = 1'b1;
          bus_rdata  = word;
          rv_sent    = 1'b1;
        end else begin
          bus_rvalid = 1'b0;
        end
        @(negedge clk);
        if (bvalid) begin
          n_valid++;
          r_addr = baddr; r_strb = bstrb;
          r_wdata = bwdata; r_wr = bwr;
          if (bus_ready) acc_at = c;
        end
        if (stall) begin
          n_stall++;
        end else begin
          r_done = 1'b1;
          r_rdata = rdata; r_fault = fault; r_code = code;
        end
        @(posedge clk); #1;
      end
    end
    lsu_req = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
    chk("access_completed", r_done, 1'b1);
    @(negedge clk);
    chk("post_done_fault", fault, 1'b0);
    chk("post_done_stall", stall, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    int  n;
    int  st;
    bit  dn;
    logic [31:0] t_rdata;
    logic        t_fault;
    logic [1:0]  t_code;

    rst = 1'b1; lsu_req = 1'b0; req2 = 1'b0; wr = 1'b0;
    f3 = 3'd0; addr = '0; wdata = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    ready2 = 1'b0; rvalid2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 1'b0);
    chk("rst_valid", bvalid, 1'b0);
    chk("rst_wr", bwr, 1'b0);
    chk("rst_addr", baddr, 32'h0);
    chk("rst_wdata", bwdata, 32'h0);
    chk("rst_strb", bstrb, 4'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_code", code, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;

    access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0);
    chk("sw_stall", n_stall, 2);
    chk("sw_valid_cycles", n_valid, 1);
    chk("sw_addr", r_addr, 32'h100);
    chk("sw_strb", r_strb, 4'b1111);
    chk("sw_wdata", r_wdata, 32'hDEADBEEF);
    chk("sw_wr", r_wr, 1'b1);
    chk("sw_fault", r_fault, 1'b0);

    access(1'b1, 3'd0, 32'h103, 32'h000000A5, 0, 1, 32'h0);
    chk("sb_addr", r_addr, 32'h100);
    chk("sb_strb", r_strb, 4'b1000);
    chk("sb_wdata", r_wdata, 32'hA5A5A5A5);

    access(1'b1, 3'd1, 32'h102, 32'h00001234, 0, 1, 32'h0);
    chk("sh_strb", r_strb, 4'b1100);
    chk("sh_wdata", r_wdata, 32'h12341234);

    access(1'b0, 3'd0, 32'h102, 32'h0, 0, 1, 32'h12803456);
    chk("lb_stall", n_stall, 3);
    chk("lb_wr", r_wr, 1'b0);
    chk("lb_addr", r_addr, 32'h100);
    chk("lb_rdata", r_rdata, 32'hFFFFFF80);
    chk("lb_fault", r_fault, 1'b0);

    access(1'b0, 3'd4, 32'h102, 32'h0, 0, 1, 32'h12803456);
    chk("lbu_rdata", r_rdata, 32'h00000080);

    access(1'b0, 3'd1, 32'h102, 32'h0, 0, 1, 32'h12803456);
    chk("lh_rdata", r_rdata, 32'h00001280);

    access(1'b0, 3'd2, 32'h100, 32'h0, 0, 1, 32'h12803456);
    chk("lw_rdata", r_rdata, 32'h12803456);

    access(1'b0, 3'd5, 32'h102, 32'h0, 0, 1, 32'hF00D0000);
    chk("lhu_rdata", r_rdata, 32'h0000F00D);

    access(1'b0, 3'd1, 32'h100, 32'h0, 0, 1, 32'h0000F00D);
    chk("lh_neg_rdata", r_rdata, 32'hFFFFF00D);

    access(1'b0, 3'd0, 32'h102, 32'h0, 3, 2, 32'h12803456);
    chk("slow_lb_stall", n_stall, 7);
    chk("slow_lb_valid", n_valid, 4);
    chk("slow_lb_rdata", r_rdata, 32'hFFFFFF80);

    access(1'b0, 3'd2, 32'h100, 32'h0, 3, 2, 32'h12803456);
    chk("slow_lw_stall", n_stall, 7);
    chk("slow_lw_rdata", r_rdata, 32'h12803456);

    access(1'b0, 3'd2, 32'h101, 32'h0, 0, 1, 32'h0);
    chk("mis_stall", n_stall, 1);
    chk("mis_valid", n_valid, 0);
    chk("mis_fault", r_fault, 1'b1);
    chk("mis_code", r_code, 2'b01);
    chk("mis_rdata", r_rdata, 32'h0);

    access(1'b0, 3'd1, 32'h103, 32'h0, 0, 1, 32'h0);
    chk("mis_lh_code", r_code, 2'b01);

    access(1'b0, 3'd3, 32'h100, 32'h0, 0, 1, 32'h0);
    chk("ill_ld_valid", n_valid, 0);
    chk("ill_ld_fault", r_fault, 1'b1);
    chk("ill_ld_code", r_code, 2'b11);

    access(1'b1, 3'd4, 32'h100, 32'h0, 0, 1, 32'h0);
    chk("ill_st_valid", n_valid, 0);
    chk("ill_st_code", r_code, 2'b11);

    access(1'b0, 3'd7, 32'h101, 32'h0, 0, 1, 32'h0);
    chk("ill_prio_code", r_code, 2'b11);

    access(1'b0, 3'd2, 32'h100, 32'h0, 0, 1, 32'h12803456);
    chk("pre_tmo_rdata", r_rdata, 32'h12803456);

    access(1'b0, 3'd2, 32'h100, 32'h0, 1000, 1, 32'h0);
    chk("tmo16_valid", n_valid, 16);
    chk("tmo16_stall", n_stall, 17);
    chk("tmo16_fault", r_fault, 1'b1);
    chk("tmo16_code", r_code, 2'b10);
    chk("tmo16_rdata", r_rdata, 32'h0);

    bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("stray_stall", stall, 1'b0);
    chk("stray_valid", bvalid, 1'b0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk("stray_rdata", rdata, 32'h0);
    chk("stray_fault", fault, 1'b0);
    @(posedge clk); #1;

    wr = 1'b0; f3 = 3'd2; addr = 32'h200; req2 = 1'b1;
    n = 0; st = 0; dn = 1'b0;
    t_rdata = '1; t_fault = 1'b0; t_code = 2'b00;
    for (int c = 0; c < 20; c++) begin
      if (!dn) begin
        @(negedge clk);
        if (bvalid2) n++;
        if (stall2) begin
          st++;
        end else begin
          dn = 1'b1;
          t_rdata = rdata2; t_fault = fault2; t_code = code2;
        end
        @(posedge clk); #1;
      end
    end
    req2 = 1'b0;
    chk("tmo4_done", dn, 1'b1);
    chk("tmo4_valid", n, 4);
    chk("tmo4_stall", st, 5);
    chk("tmo4_fault", t_fault, 1'b1);
    chk("tmo4_code", t_code, 2'b10);
    chk("tmo4_rdata", t_rdata, 32'h0);

    access(1'b0, 3'd2, 32'h100, 32'h0, 0, 1, 32'h5A5A1234);
    chk("pre_rst_rdata", r_rdata, 32'h5A5A1234);

    lsu_req = 1'b1; wr = 1'b0; f3 = 3'd2; addr = 32'h100;
    @(posedge clk); #1;
    bus_ready = 1'b1;
    @(negedge clk);
    chk("rst_seq_req_valid", bvalid, 1'b1);
    @(posedge clk); #1;
    bus_ready = 1'b0;
    @(negedge clk);
    chk("rst_seq_resp_stall", stall, 1'b1);
    chk("rst_seq_resp_valid", bvalid, 1'b0);
    #1;
    rst = 1'b1; lsu_req = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
    #1;
    chk("rst_async_stall", stall, 1'b0);
    chk("rst_async_valid", bvalid, 1'b0);
    chk("rst_async_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after_stall", stall, 1'b0);
    chk("rst_after_rdata", rdata, 32'h0);
    chk("rst_after_fault", fault, 1'b0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;

    access(1'b1, 3'd2, 32'h104, 32'h01020304, 0, 1, 32'h0);
    chk("post_rst_sw_stall", n_stall, 2);
    chk("post_rst_sw_addr", r_addr, 32'h104);
    chk("post_rst_sw_wdata", r_wdata, 32'h01020304);
    chk("post_rst_sw_fault", r_fault, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
